// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared pipeline constants and arbiter state encoding
//
// Purpose: state encoding for the data-memory port arbiter and the default
// DATA_W / ADDR_W widths shared with the EX/MEM and MEM/WB pipeline registers.
package dmem_port_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;

  localparam logic ARB_IDLE   = 1'b0;
  localparam logic ARB_SERVE1 = 1'b1;

  typedef enum logic {
    ST_IDLE   = ARB_IDLE,
    ST_SERVE1 = ARB_SERVE1
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_perf_cnt.sv
// rtl/dmem_arb_perf_cnt.sv - saturating event counter for arbiter conflicts
//
// Purpose: counts conflict events, sticks at all-ones, cleared only by reset.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous reset, active-high
//   inc_i   in   one-cycle event pulse
//   cnt_o   out  CNT_W-bit saturating count
module dmem_arb_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - single-port data memory arbiter for the two issue slots
//
// Purpose: shares one data memory port between slot0 (older) and slot1
// (younger). A same-cycle conflict is serialized in program order: slot0 is
// served while mem_stall freezes the pipeline, slot1 is served the next cycle.
// Optional feature macro: DMEM_ARB_PERF_CNT_EN (saturating conflict counter;
// when undefined conflict_cnt is tied to 0).
// Ports:
//   clk, reset                          clock / async active-high reset
//   mem_read_sN, mem_write_sN           slot N load / store in MEM stage
//   addr_sN, wdata_sN                   slot N word address / store data
//   dmem_rdata                          combinational memory read data
//   dmem_addr, dmem_wdata, dmem_we      memory address / write data / write enable
//   rdata_s0, rdata_s1                  load results toward MEM/WB
//   mem_stall                           freeze pipeline up to EX/MEM
//   grant_s1                            current access belongs to slot1
//   conflict_cnt                        conflict count (optional feature)
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_s0,
  input  logic              mem_write_s0,
  input  logic [ADDR_W-1:0] addr_s0,
  input  logic [DATA_W-1:0] wdata_s0,
  input  logic              mem_read_s1,
  input  logic              mem_write_s1,
  input  logic [ADDR_W-1:0] addr_s1,
  input  logic [DATA_W-1:0] wdata_s1,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic [DATA_W-1:0] rdata_s0,
  output logic [DATA_W-1:0] rdata_s1,
  output logic              mem_stall,
  output logic              grant_s1,
  output logic [CNT_W-1:0]  conflict_cnt
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              req0, req1;

  // A slot with both read and write set is treated as a store, since the
  // write enable is taken straight from mem_write.
  assign req0 = mem_read_s0 | mem_write_s0;
  assign req1 = mem_read_s1 | mem_write_s1;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    dmem_addr  = addr_s0;
    dmem_wdata = wdata_s0;
    dmem_we    = 1'b0;
    mem_stall  = 1'b0;
    grant_s1   = 1'b0;
    rdata_s0   = '0;
    rdata_s1   = '0;

    case (state_q)
      ST_IDLE: begin
        if (req0) begin
          dmem_we  = mem_write_s0;
          rdata_s0 = dmem_rdata;
          if (req1) begin
            // Keep slot0's load data across the freeze cycle.
            mem_stall = 1'b1;
            hold_d    = dmem_rdata;
            state_d   = ST_SERVE1;
          end
        end else if (req1) begin
          dmem_addr  = addr_s1;
          dmem_wdata = wdata_s1;
          dmem_we    = mem_write_s1;
          grant_s1   = 1'b1;
          rdata_s1   = dmem_rdata;
        end
      end
      ST_SERVE1: begin
        // Pipeline is frozen, so slot1 inputs still hold the deferred access.
        dmem_addr  = addr_s1;
        dmem_wdata = wdata_s1;
        dmem_we    = mem_write_s1;
        grant_s1   = 1'b1;
        rdata_s0   = hold_q;
        rdata_s1   = dmem_rdata;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs drop immediately with reset, so an abandoned slot1 store
    // cannot land while reset is held.
    if (reset) begin
      dmem_we   = 1'b0;
      mem_stall = 1'b0;
      grant_s1  = 1'b0;
      rdata_s0  = '0;
      rdata_s1  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

`ifdef DMEM_ARB_PERF_CNT_EN
  logic conflict_start;
  assign conflict_start = (state_q == ST_IDLE) & req0 & req1;

  dmem_arb_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (conflict_start),
    .cnt_o (conflict_cnt)
  );
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_read_s0 = 1'b0, mem_write_s0 = 1'b0;
  logic          mem_read_s1 = 1'b0, mem_write_s1 = 1'b0;
  logic [AW-1:0] addr_s0 = '0, addr_s1 = '0;
  logic [DW-1:0] wdata_s0 = '0, wdata_s1 = '0;
  logic [DW-1:0] dmem_rdata;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_we;
  logic [DW-1:0] rdata_s0, rdata_s1;
  logic          mem_stall, grant_s1;
  logic [CW-1:0] conflict_cnt;

  // Memory environment with a preload path used while reset holds the DUT.
  logic [DW-1:0] mem [256];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  // Reference model state: the memory as program-order execution sees it.
  logic [DW-1:0] ref_mem [256];
  int            conflicts = 0;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  assign dmem_rdata = mem[dmem_addr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (dmem_we) mem[dmem_addr] <= dmem_wdata;
  end

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read_s0  (mem_read_s0),
    .mem_write_s0 (mem_write_s0),
    .addr_s0      (addr_s0),
    .wdata_s0     (wdata_s0),
    .mem_read_s1  (mem_read_s1),
    .mem_write_s1 (mem_write_s1),
    .addr_s1      (addr_s1),
    .wdata_s1     (wdata_s1),
    .dmem_rdata   (dmem_rdata),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_we      (dmem_we),
    .rdata_s0     (rdata_s0),
    .rdata_s1     (rdata_s1),
    .mem_stall    (mem_stall),
    .grant_s1     (grant_s1),
    .conflict_cnt (conflict_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef DMEM_ARB_PERF_CNT_EN
    return (conflicts > 3) ? 32'd3 : conflicts;
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    mem_read_s0 = r0; mem_write_s0 = w0; addr_s0 = a0; wdata_s0 = d0;
    mem_read_s1 = r1; mem_write_s1 = w1; addr_s1 = a1; wdata_s1 = d1;
  endtask

  // One pipeline bundle: both slots present their MEM-stage ops. Called at
  // posedge+1; returns at posedge+1 after the bundle has retired.
  task automatic run_pair(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic q0, q1;
    logic [DW-1:0] old0;
    q0 = r0 | w0;
    q1 = r1 | w1;
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    @(negedge clk);
    if (q0 && q1) begin
      check_eq("conf_stall_c0", mem_stall, 1);
      check_eq("conf_grant_c0", grant_s1, 0);
      check_eq("conf_we_c0", dmem_we, w0);
      check_eq("conf_rd0_c0", rdata_s0, ref_mem[a0]);
      old0 = ref_mem[a0];
      @(posedge clk);
      if (w0) ref_mem[a0] = d0;
      conflicts++;
      #1;
      @(negedge clk);
      check_eq("conf_stall_c1", mem_stall, 0);
      check_eq("conf_grant_c1", grant_s1, 1);
      check_eq("conf_we_c1", dmem_we, w1);
      check_eq("conf_rd0_c1", rdata_s0, old0);
      check_eq("conf_rd1_c1", rdata_s1, ref_mem[a1]);
      check_eq("conf_cnt", conflict_cnt, exp_cnt());
      @(posedge clk);
      if (w1) ref_mem[a1] = d1;
      #1;
    end else begin
      check_eq("single_stall", mem_stall, 0);
      check_eq("single_grant", grant_s1, q1 && !q0);
      check_eq("single_we", dmem_we, q0 ? w0 : (q1 ? w1 : 1'b0));
      check_eq("single_rd0", rdata_s0, q0 ? ref_mem[a0] : 32'h0);
      check_eq("single_rd1", rdata_s1, q1 ? ref_mem[a1] : 32'h0);
      check_eq("single_cnt", conflict_cnt, exp_cnt());
      @(posedge clk);
      if (q0 && w0) ref_mem[a0] = d0;
      else if (q1 && w1) ref_mem[a1] = d1;
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[8'h05] = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'h11111111;
    ref_mem[8'h11] = 32'h22222222;
    ref_mem[8'h30] = 32'h00000000;

    // Preload under reset; the DUT must keep dmem_we low throughout.
    ld_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_addr = i[AW-1:0];
      ld_data = ref_mem[i];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
    check_eq("rst_we", dmem_we, 0);
    check_eq("rst_stall", mem_stall, 0);
    check_eq("rst_grant", grant_s1, 0);
    check_eq("rst_rd0", rdata_s0, 0);
    check_eq("rst_rd1", rdata_s1, 0);
    check_eq("rst_cnt", conflict_cnt, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Only slot1 loads 0x05.
    drive(0, 0, 8'h00, 0, 1, 0, 8'h05, 0);
    @(negedge clk);
    check_eq("s1_only_rd1", rdata_s1, 32'hDEADBEEF);
    check_eq("s1_only_grant", grant_s1, 1);
    check_eq("s1_only_stall", mem_stall, 0);
    @(posedge clk); #1;

    // Two loads in conflict.
    run_pair(1, 0, 8'h10, 0, 1, 0, 8'h11, 0);
    // Store then load to the same address: slot1 sees the new data.
    run_pair(0, 1, 8'h20, 32'hA5A5A5A5, 1, 0, 8'h20, 0);
    // Load then store to the same address: slot0 sees the old data.
    run_pair(1, 0, 8'h30, 0, 0, 1, 8'h30, 32'h00000077);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("mem30_after", mem[8'h30], 32'h00000077);
    check_eq("mem20_after", mem[8'h20], 32'hA5A5A5A5);
    @(posedge clk); #1;

    // Five back-to-back conflicts drive the 2-bit counter into saturation.
    for (int k = 0; k < 5; k++) begin
      run_pair(1, 0, 8'h40 + k[AW-1:0], 0, 1, 0, 8'h50 + k[AW-1:0], 0);
    end
    check_eq("cnt_saturated", conflict_cnt, exp_cnt());

    // Randomized bundles over a narrow address window to force aliasing.
    for (int k = 0; k < 200; k++) begin
      run_pair($urandom_range(0, 1), $urandom_range(0, 1), 8'h60 + 8'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 1), $urandom_range(0, 1), 8'h60 + 8'($urandom_range(0, 7)), $urandom);
    end

    // Reset in the middle of SERVE1: slot1 store must be abandoned.
    drive(1, 0, 8'h70, 0, 0, 1, 8'h71, 32'hCAFEF00D);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("midrst_we", dmem_we, 0);
    check_eq("midrst_stall", mem_stall, 0);
    check_eq("midrst_grant", grant_s1, 0);
    check_eq("midrst_rd0", rdata_s0, 0);
    check_eq("midrst_rd1", rdata_s1, 0);
    check_eq("midrst_cnt", conflict_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    conflicts = 0;
    @(negedge clk);
    check_eq("postrst_stall", mem_stall, 0);
    check_eq("postrst_we", dmem_we, 0);
    check_eq("postrst_rd0", rdata_s0, 0);
    check_eq("postrst_rd1", rdata_s1, 0);
    check_eq("postrst_mem71", mem[8'h71], ref_mem[8'h71]);
    @(posedge clk); #1;

    // A fresh pair after reset behaves normally from IDLE.
    run_pair(1, 0, 8'h71, 0, 1, 0, 8'h05, 0);

    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) check_eq("final_mem", mem[i], ref_mem[i]);
    end
    check_eq("final_mem_71", mem[8'h71], ref_mem[8'h71]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the two issue slots (slot0 = older, slot1 = younger) of the dual-issue pipeline.
- Sits between the two slot-wise EX/MEM pipeline registers and the data memory.
- When both slots need memory in the same cycle, it serializes the accesses in program order (slot0 first, then slot1).
- While it does so, it asserts a stall that freezes the IF..EX/MEM pipeline registers for one cycle.

Parameters:
- ADDR_W, 8, data-memory word-address width.
- DATA_W, 32, data width.
- CNT_W, 16, width of the optional conflict counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- mem_read_s0  in  1  slot0 load in MEM stage.
- mem_write_s0  in  1  slot0 store in MEM stage.
- addr_s0  in  ADDR_W  slot0 word address (ALU result).
- wdata_s0  in  DATA_W  slot0 store data.
- mem_read_s1, mem_write_s1, addr_s1, wdata_s1  in  1/1/ADDR_W/DATA_W  same for slot1.
- dmem_rdata  in  DATA_W  memory read data, combinational from dmem_addr.
- dmem_addr  out  ADDR_W  memory address.
- dmem_wdata  out  DATA_W  memory write data.
- dmem_we  out  1  memory write enable (written at rising clk).
- rdata_s0  out  DATA_W  load result for slot0 toward MEM/WB.
- rdata_s1  out  DATA_W  load result for slot1 toward MEM/WB.
- mem_stall  out  1  freeze all pipeline registers up to and including EX/MEM; bubble MEM/WB inputs of slot1.
- grant_s1  out  1  current access belongs to slot1.
- conflict_cnt  out  CNT_W  present only with the optional feature.

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous, active-high.
- On reset:
  - state = IDLE, held rdata register = 0.
  - All outputs 0: dmem_we = 0, mem_stall = 0, grant_s1 = 0, rdata_s0 = rdata_s1 = 0, conflict_cnt = 0.
- Request decode:
  - req0 = mem_read_s0 | mem_write_s0.
  - req1 = mem_read_s1 | mem_write_s1.
  - read and write both high on one slot is illegal; write wins.
- FSM states: IDLE, SERVE1.
- IDLE, req0 & req1:
  - Serve slot0: dmem_addr = addr_s0, dmem_we = mem_write_s0.
  - mem_stall = 1, grant_s1 = 0.
  - At the clock edge: capture dmem_rdata into hold_rdata and go to SERVE1.
- IDLE, exactly one request:
  - Serve that slot combinationally, zero added latency.
  - grant_s1 = req1, mem_stall = 0, stay in IDLE.
- IDLE, no request:
  - dmem_addr = addr_s0, dmem_we = 0, mem_stall = 0.
- SERVE1 (exactly one cycle):
  - Serve slot1 (inputs are unchanged because the pipeline is frozen).
  - mem_stall = 0, grant_s1 = 1.
  - rdata_s0 = hold_rdata; rdata_s1 = dmem_rdata.
  - Return to IDLE unconditionally.
- rdata outside SERVE1:
  - rdata_s0 = dmem_rdata when slot0 is served, else 0.
  - rdata_s1 = dmem_rdata when slot1 is served, else 0.
- Ordering:
  - slot0 store then slot1 load to the same address: the load returns the new data, because the write commits at the first edge.
  - slot0 load then slot1 store to the same address: slot0 gets the old data.
- Mem data outputs:
  - mem_stall, dmem_* and rdata_* are combinational from state and inputs.
  - hold_rdata and state are registered.
- Reset asserted in SERVE1:
  - Immediate return to IDLE; slot1 access abandoned.
  - dmem_we drops asynchronously with reset.
- Maximum stall: one cycle per conflicting pair. mem_stall is never high two cycles in a row for the same pair.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- Defined:
  - conflict_cnt increments once per IDLE->SERVE1 transition.
  - Saturates at all-ones; cleared only by reset.
- Undefined:
  - Counter logic absent; conflict_cnt is tied to 0 (the port remains).

Decomposition:
- Shared pipeline package holds:
  - state encoding localparams ARB_IDLE = 1'b0, ARB_SERVE1 = 1'b1;
  - DATA_W / ADDR_W defaults, shared with the EX/MEM and MEM/WB registers.
- One natural sub-module: dmem_arb_perf_cnt (saturating counter), instantiated only under DMEM_ARB_PERF_CNT_EN.

Test Plan:
- Reset asserted mid-SERVE1 -> next observation: state IDLE, mem_stall = 0, dmem_we = 0, rdata outputs = 0, conflict_cnt = 0.
- Only slot1 loads addr 0x05 holding 0xDEADBEEF -> same cycle: rdata_s1 = 0xDEADBEEF, grant_s1 = 1, mem_stall = 0.
- Slot0 loads 0x10 (=0x11111111), slot1 loads 0x11 (=0x22222222):
  - cycle0: mem_stall = 1.
  - cycle1: rdata_s0 = 0x11111111, rdata_s1 = 0x22222222, mem_stall = 0.
- Slot0 stores 0xA5A5A5A5 to 0x20, slot1 loads 0x20 -> cycle1 rdata_s1 = 0xA5A5A5A5.
- Slot0 loads 0x30 (=0x0), slot1 stores 0x77 to 0x30 -> rdata_s0 = 0x0; afterwards mem[0x30] = 0x77.
- With DMEM_ARB_PERF_CNT_EN and CNT_W = 2, five back-to-back conflict pairs -> conflict_cnt = 3 (saturated), no wrap.
